// File: rtl/mul_pkg.sv
// Shared types and helpers for the M-extension multiply controller.
// Op encoding follows funct3[1:0].
package mul_pkg;

    localparam int MUL_XLEN = 32;

    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,
        OP_MULH   = 2'd1,
        OP_MULHSU = 2'd2,
        OP_MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DRAIN,
        S_RESP
    } mul_state_e;

    // MUL and MULH take the signed product; MULHSU is fixed up from unsigned
    function automatic logic mul_needs_signed(mul_op_e op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

    function automatic logic [MUL_XLEN-1:0] mul_select(
        mul_op_e                   op,
        logic [2*MUL_XLEN-1:0]     p,
        logic                      a_msb,
        logic [MUL_XLEN-1:0]       b
    );
        logic [MUL_XLEN-1:0] hi;
        logic [MUL_XLEN-1:0] rd;
        hi = p[2*MUL_XLEN-1:MUL_XLEN];
        unique case (op)
            OP_MUL:    rd = p[MUL_XLEN-1:0];
            OP_MULHSU: rd = hi - (a_msb ? b : '0);
            default:   rd = hi;
        endcase
        return rd;
    endfunction

endpackage

// File: rtl/mul_ctrl_multiply.sv
// Shared multi-cycle multiply primitive with stb/ack handshake.
// Operands must stay stable while stb is high; ack pulses one cycle.
module multiply #(
    parameter int A_W     = 32,
    parameter int B_W     = 32,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stb,
    input  logic                 is_signed,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    output logic                 ack,
    output logic [A_W+B_W-1:0]   product
);

    localparam int P_W = A_W + B_W;

    logic           run;
    logic [3:0]     cnt;
    logic [P_W-1:0] ea;
    logic [P_W-1:0] eb;

    // extend operands to product width so one multiply covers both modes
    always_comb begin
        ea = is_signed ? {{B_W{a[A_W-1]}}, a} : {{B_W{1'b0}}, a};
        eb = is_signed ? {{A_W{b[B_W-1]}}, b} : {{A_W{1'b0}}, b};
    end

    // count out the latency, then pulse ack with the product
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run     <= 1'b0;
            cnt     <= '0;
            ack     <= 1'b0;
            product <= '0;
        end else begin
            ack <= 1'b0;
            if (run) begin
                if (cnt == '0) begin
                    run     <= 1'b0;
                    ack     <= 1'b1;
                    product <= ea * eb;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end else if (stb && !ack) begin
                run <= 1'b1;
                cnt <= 4'(LATENCY - 1);
            end
        end
    end

endmodule

// File: rtl/mul_ctrl.sv
// Sequences the multiply primitive for MUL/MULH/MULHSU/MULHU.
// A one-entry product cache lets MULH+MUL pairs share one multiply.
module mul_ctrl
    import mul_pkg::*;
#(
    parameter int XLEN     = MUL_XLEN,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data
);

    mul_state_e        state;
    mul_state_e        state_n;
    mul_op_e           op_in;
    mul_op_e           op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic              sgn_q;
    logic              stb;
    logic              ack;
    logic [2*XLEN-1:0] product;

    logic              c_valid;
    logic              c_sgn;
    logic [XLEN-1:0]   c_a;
    logic [XLEN-1:0]   c_b;
    logic [2*XLEN-1:0] c_prod;

    logic              hit;
    logic              accept;
    logic              fill;

    assign op_in     = mul_op_e'(req_op);
    assign req_ready = (state == S_IDLE) && !flush;
    assign rsp_valid = (state == S_RESP);

    // MUL low word is the same in either mode, so any cached mode serves it
    assign hit = CACHE_EN && c_valid
              && (req_a == c_a) && (req_b == c_b)
              && ((op_in == OP_MUL) || (c_sgn == mul_needs_signed(op_in)));

    multiply #(
        .A_W (XLEN),
        .B_W (XLEN)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .stb       (stb),
        .is_signed (sgn_q),
        .a         (a_q),
        .b         (b_q),
        .ack       (ack),
        .product   (product)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // next state; a started multiply is always drained to its ack
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        fill    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    accept  = 1'b1;
                    state_n = hit ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (ack) begin
                    state_n = flush ? S_IDLE : S_RESP;
                    fill    = !flush;
                end else if (flush) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ack) state_n = S_IDLE;
            end
            S_RESP: begin
                if (flush || rsp_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // operand latch, strobe and response register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            stb      <= 1'b0;
            rsp_data <= '0;
        end else begin
            stb <= (state_n == S_BUSY) || (state_n == S_DRAIN);
            if (accept) begin
                op_q  <= op_in;
                a_q   <= req_a;
                b_q   <= req_b;
                sgn_q <= mul_needs_signed(op_in);
                if (hit)
                    rsp_data <= mul_select(op_in, c_prod,
                                           req_a[XLEN-1], req_b);
            end
            if (fill)
                rsp_data <= mul_select(op_q, product, a_q[XLEN-1], b_q);
        end
    end

    // single cache entry, refilled only by a completed, unflushed miss
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_valid <= 1'b0;
            c_sgn   <= 1'b0;
            c_a     <= '0;
            c_b     <= '0;
            c_prod  <= '0;
        end else if (fill && CACHE_EN) begin
            c_valid <= 1'b1;
            c_sgn   <= sgn_q;
            c_a     <= a_q;
            c_b     <= b_q;
            c_prod  <= product;
        end
    end

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Sequences the shared `multiply` primitive for the RV32 M-extension ops MUL, MULH, MULHSU and MULHU.
- Sits between the execute-stage issue logic and the multiply primitive: valid/ready request channel in, valid/ready response channel out.
- Drives the primitive's stb/ack handshake and derives MULHSU with a sign fixup.
- Keeps a one-entry product cache so that a MULH[S][U]/MUL pair on the same operands issues the primitive only once.

Parameters:
- XLEN, 32, operand width; product width is 2*XLEN.
- CACHE_EN, 1, 1 = one-entry product cache present; 0 = every request misses.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- flush  in  1  abandon the current request; no response for it.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_op  in  2  mul_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3 (funct3[1:0]).
- req_a  in  XLEN  rs1 value.
- req_b  in  XLEN  rs2 value.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_data  out  XLEN  rd value.

Behaviour:
- Reset (rst low, async): state IDLE, req_ready=1, rsp_valid=0, rsp_data=0, cache valid=0, internal stb=0.
- States: IDLE, BUSY, DRAIN, RESP.
- req_ready = (state==IDLE) && !flush.
- Product mode: MUL and MULH use the signed product. MULHU and MULHSU use the unsigned product.
- MULHSU high word = unsigned high word - (a[XLEN-1] ? b : 0), mod 2^XLEN.
- MUL low word is mode-independent.
- Cache hit requires CACHE_EN and valid entry and a==tag_a and b==tag_b, plus one of:
  - op==MUL (either cached mode);
  - stored mode equals the mode required by op.
- IDLE, accept in cycle T:
  - On hit: go to RESP; rsp_data is computed from the cached product; rsp_valid=1 at T+1.
  - On miss: latch a, b, op and mode; go to BUSY; stb=1 from T+1.
- BUSY:
  - stb held high with stable operands and is_signed=(mode==signed) until ack.
  - On ack in cycle A: write the cache (tag a/b, mode, full product); register rsp_data; go to RESP; rsp_valid=1 at A+1; stb low at A+1.
- RESP: rsp_valid held with stable data until rsp_ready; on handshake go to IDLE, so the next request can be accepted the following cycle. There is no same-cycle back-to-back issue.
- Flush rules:
  - IDLE: no accept this cycle.
  - RESP: rsp_valid drops next cycle; go to IDLE.
  - BUSY without ack: go to DRAIN; stb stays high, because the primitive cannot be aborted.
  - BUSY with ack in the same cycle: go to IDLE; result discarded; cache not written.
  - DRAIN: on ack, go to IDLE; result discarded; cache not written; flush has no further effect.
- flush and rsp_ready in the same RESP cycle: treated as flush (same next state, IDLE).
- Cache write on a miss overwrites the single entry. The cache is never written on hit, flush or drain.
- Reset mid-operation clears everything. The primitive is reset by the same rst through its own reset handling, so no stale ack is accepted after reset.
- Widths: the full product is 2*XLEN. Selection is low word for MUL, high word otherwise; MULHSU subtraction wraps mod 2^XLEN.

Decomposition:
- Package mul_pkg holds:
  - mul_op_e (2-bit enum, values as above);
  - mul_state_e;
  - function mul_needs_signed(op);
  - function mul_select(op, product, a_msb, b) returning rd.
- One sub-module: an instance of the existing `multiply` primitive with A_W=B_W=XLEN.
- Cache registers, FSM and fixup stay inline in mul_ctrl.

Test Plan:
- MULH a=0xFFFFFFFE, b=0x00000003, then MUL with the same operands:
  - rsp 0xFFFFFFFF for MULH;
  - MUL returns 0xFFFFFFFA with rsp_valid 1 cycle after accept;
  - no stb for the MUL.
- MULHSU a=0xFFFFFFFF, b=0x00000002 -> rsp 0xFFFFFFFF. MULHU same operands -> 0x00000001; hit, no stb. MULH same operands -> miss, stb issued, rsp 0xFFFFFFFF.
- MUL a=7, b=6 with rsp_ready low for 5 cycles -> rsp_valid and rsp_data=42 stable throughout; req_ready low until the cycle after the handshake.
- Flush in BUSY 1 cycle after stb rises:
  - stb held until ack, then IDLE;
  - no rsp_valid;
  - a following identical MULH misses (stb issued).
- rst low while BUSY -> rsp_valid=0, req_ready=1, stb=0 immediately. After release, a repeat of the previous request misses.
- CACHE_EN=0: MULH then MUL on equal operands -> both issue stb; results match a reference model over 1000 random ops with random rsp_ready back-pressure.
